// File: rtl/dual_ram_pkg.sv
// Shared types for the parametrised dual-port RAM.
package dual_ram_pkg;

   typedef enum logic {S_CLEAR, S_READY} ram_state_e;

endpackage

// File: rtl/dual_ram_core.sv
// Bare storage array: one synchronous write port, one combinational read port, no reset.
module dual_ram_core #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_c = mem[raddr];

endmodule

// File: rtl/dual_ram_param.sv
// Dual-port RAM with registered read, write-first bypass and a hardware clear sequencer
// that zeroes every entry after reset or on a clr request.
module dual_ram_param
   import dual_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy
);

   // One extra bit so a power-of-two DEPTH is representable in the range compare.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   ram_state_e        state;
   logic [ADDR_W-1:0] clr_ptr;

   logic              clearing_c;
   logic              accept_c;
   logic              wr_ok_c;
   logic              rd_in_c;
   logic              bypass_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_waddr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic [DATA_W-1:0] mem_rdata_c;

   assign clearing_c  = (state == S_CLEAR);
   assign accept_c    = (state == S_READY) && !clr;
   assign wr_ok_c     = wr_en && ({1'b0, wr_addr} < DEPTH_X);
   assign rd_in_c     = ({1'b0, rd_addr} < DEPTH_X);
   assign bypass_c    = wr_ok_c && rd_in_c && (rd_addr == wr_addr);

   // Clear sequencer owns the write port while it runs.
   assign mem_we_c    = clearing_c || (accept_c && wr_ok_c);
   assign mem_waddr_c = clearing_c ? clr_ptr : wr_addr;
   assign mem_wdata_c = clearing_c ? '0 : wr_data;

   dual_ram_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk     (clk),
      .we      (mem_we_c),
      .waddr   (mem_waddr_c),
      .wdata   (mem_wdata_c),
      .raddr   (rd_addr),
      .rdata_c (mem_rdata_c)
   );

   // Control FSM plus read-data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_CLEAR;
         clr_ptr  <= '0;
         busy     <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            S_CLEAR: begin
               if (clr_ptr == LAST) begin
                  state   <= S_READY;
                  busy    <= 1'b0;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + ADDR_W'(1);
               end
            end
            S_READY: begin
               if (clr) begin
                  state   <= S_CLEAR;
                  busy    <= 1'b1;
                  clr_ptr <= '0;
               end else if (rd_en) begin
                  rd_valid <= 1'b1;
                  if (bypass_c)     rd_data <= wr_data;
                  else if (rd_in_c) rd_data <= mem_rdata_c;
                  else              rd_data <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dual_ram_param.sv
// Randomised scoreboard bench: DEPTH=8 and DEPTH=5 instances share one stimulus stream
// and are each checked against an array-based reference model.
module tb_dual_ram_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [2:0]  rd_addr;

   logic [15:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        busy0, busy1;

   always #5 clk = ~clk;

   dual_ram_param #(.DATA_W(16), .DEPTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
   );

   dual_ram_param #(.DATA_W(16), .DEPTH(5)) u_dut5 (
      .clk(clk), .reset(reset), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
   );

   // Reference model: an array per instance, a count of clear cycles left, and a queue of
   // expected read results.
   int          depth     [2];
   logic [15:0] mem       [2][8];
   int          clr_left  [2];
   logic        exp_busy  [2];
   logic        exp_valid [2];
   logic [15:0] last      [2];
   logic [15:0] q0[$];
   logic [15:0] q1[$];

   int tests = 0;
   int fails = 0;

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         clr_left[d]  = depth[d];
         exp_busy[d]  = 1'b1;
         exp_valid[d] = 1'b0;
         last[d]      = 16'h0;
         for (int i = 0; i < 8; i++) mem[d][i] = 16'h0;
      end
      q0.delete();
      q1.delete();
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      logic [15:0] v;
      if (reset) return;
      for (int d = 0; d < 2; d++) begin
         if (clr_left[d] > 0) begin
            clr_left[d]--;
            exp_valid[d] = 1'b0;
         end else if (clr) begin
            clr_left[d]  = depth[d];
            exp_valid[d] = 1'b0;
            for (int i = 0; i < 8; i++) mem[d][i] = 16'h0;
         end else begin
            exp_valid[d] = rd_en;
            if (rd_en) begin
               v = 16'h0;
               if (int'(rd_addr) < depth[d])
                  v = (wr_en && wr_addr == rd_addr) ? wr_data : mem[d][rd_addr];
               if (d == 0) q0.push_back(v);
               else        q1.push_back(v);
            end
            if (wr_en && int'(wr_addr) < depth[d]) mem[d][wr_addr] = wr_data;
         end
         exp_busy[d] = (clr_left[d] > 0);
      end
   endtask

   task automatic check(input int d, input logic b, input logic v, input logic [15:0] dat);
      logic [15:0] e;
      tests++;
      if (b !== exp_busy[d]) begin
         fails++;
         $display("FAIL busy depth%0d t=%0t: got %b expected %b", depth[d], $time, b, exp_busy[d]);
      end
      tests++;
      if (v !== exp_valid[d]) begin
         fails++;
         $display("FAIL rd_valid depth%0d t=%0t: got %b expected %b", depth[d], $time, v, exp_valid[d]);
      end
      if (v === 1'b1) begin
         tests++;
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_read depth%0d t=%0t: got %h expected no read", depth[d], $time, dat);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (dat !== e) begin
               fails++;
               $display("FAIL rd_data depth%0d t=%0t: got %h expected %h", depth[d], $time, dat, e);
            end
            last[d] = e;
         end
      end else begin
         tests++;
         if (dat !== last[d]) begin
            fails++;
            $display("FAIL rd_hold depth%0d t=%0t: got %h expected %h", depth[d], $time, dat, last[d]);
         end
      end
   endtask

   // Monitor: samples both instances just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      check(0, busy0, rd_valid0, rd_data0);
      check(1, busy1, rd_valid1, rd_data1);
   end

   task automatic step(input logic c, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra);
      @(negedge clk);
      clr = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_edge();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      release_reset();
   endtask

   initial begin
      depth[0] = 8;
      depth[1] = 5;
      reset = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 16'h0;
      #1;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      release_reset();
      idle(8);

      // Post-reset contents are zero.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));

      // Fill 1..8, read back-to-back.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 16'(i + 1), 1'b0, 3'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));

      // Same-cycle write/read bypass.
      step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3);

      // Clear with ignored traffic, then confirm addr 2 is zero.
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd2, 16'h1234, 1'b1, 3'd2);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);

      // Reset during clear cycle 4 restarts a full-length clear.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 16'($urandom), 1'b0, 3'd0);
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      idle(3);
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));

      // Out-of-range write and read on the DEPTH=5 instance.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(i), 16'h1100 + 16'(i), 1'b0, 3'd0);
      step(1'b0, 1'b1, 3'd6, 16'hAAAA, 1'b0, 3'd0);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));

      // A pending rd_valid is killed as soon as reset rises.
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      tests++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
         fails++;
         $display("FAIL async_kill: got %b%b expected 00", rd_valid0, rd_valid1);
      end
      tests++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
         fails++;
         $display("FAIL async_busy: got %b%b expected 11", busy0, busy1);
      end
      repeat (2) @(negedge clk);
      release_reset();

      // Random traffic including occasional clears.
      for (int n = 0; n < 1500; n++)
         step($urandom_range(59) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
              1'($urandom), 3'($urandom));

      idle(12);
      @(posedge clk);
      #2;
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL pending_reads: got %0d/%0d expected 0/0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dual_ram_param.md
# dual_ram_param

Parametrised dual-port RAM with one write port and one registered read port, the successor to the fixed 8x16 record store used by the parking-system datapath. It adds configurable width and depth, a one-cycle registered read with a valid flag, and write-first bypass. It also has a hardware clear sequencer that zeroes every entry after reset or on request, so downstream logic never reads uninitialised memory.

## Interface
Parameters:
- DATA_W, 16, word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of 2)
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  input  1  single clock; all state changes on posedge
- reset  input  1  asynchronous, active-high reset
- clr  input  1  one-cycle request to re-zero the whole array
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd_en  input  1  read strobe
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data; holds between reads
- rd_valid  output  1  high for exactly one cycle when rd_data was updated by a read
- busy  output  1  high while the clear sequence runs; port ops are ignored

## Operation
- Two states: S_CLEAR and S_READY.
- Reset asserted (asynchronous):
  - state=S_CLEAR, clear pointer=0.
  - busy=1, rd_data=0, rd_valid=0.
  - Array contents are not touched by reset itself.
- S_CLEAR:
  - Each cycle, write 0 to entry [clear pointer], then increment the pointer.
  - After writing entry DEPTH-1, go to S_READY.
  - wr_en, rd_en and clr are ignored; rd_valid=0; rd_data holds its value.
- S_READY:
  - clr=1 → S_CLEAR, pointer=0. A write or read in that same cycle is ignored.
  - wr_en=1 with wr_addr<DEPTH → entry written at the edge.
  - wr_en=1 with wr_addr≥DEPTH → write dropped.
  - rd_en=1 → at the next edge, rd_data loads the entry and rd_valid=1.
  - rd_en=1 with rd_addr≥DEPTH → rd_data=0, rd_valid=1.
  - rd_en=0 → rd_valid=0 and rd_data holds.
- Write-first bypass: rd_en and wr_en in the same cycle with rd_addr==wr_addr (both in range) → rd_data=wr_data.
- Both ports may be active every cycle; there is no back-pressure.
- Widths: all addresses are compared at full ADDR_W, with no truncation or wrap.

## Timing
- Read latency: 1 cycle from the rd_en edge to rd_data/rd_valid.
- Write visibility:
  - Same cycle via bypass.
  - Otherwise, any read issued on or after the edge following the write.
- Clear duration: exactly DEPTH cycles.
  - After reset: busy falls on the DEPTH-th rising edge after reset deasserts.
  - After clr: busy rises on the edge that samples clr and falls DEPTH edges later.
- First accepted operation: the first edge at which busy is sampled 0.
- Reset mid-clear or mid-read: the clear restarts from pointer 0; any pending rd_valid is killed immediately (asynchronously).

## Structure
- Package dual_ram_pkg: typedef enum logic {S_CLEAR, S_READY} ram_state_e.
- Sub-module dual_ram_core: bare storage array.
  - Parameters DATA_W and DEPTH.
  - Ports: one synchronous write port and a combinational read.
  - No reset.
- Top level owns:
  - the FSM,
  - the clear pointer (ADDR_W bits),
  - the write mux (clear vs. user write),
  - range checks,
  - the bypass compare,
  - the rd_data/rd_valid registers.

## Test plan
Default parameters (DEPTH=8, DATA_W=16) unless stated.
- Reset release → busy=1 for 8 cycles, then 0. Reads of all addresses 0..7 return 0x0000 with rd_valid pulsing once each.
- Write 0x0001..0x0008 to addresses 0..7, then read 0..7 back-to-back → rd_data = 1..8 on consecutive cycles, each 1 cycle after its rd_en.
- Write addr 3 = 0xBEEF and read addr 3 in the same cycle → next cycle rd_data=0xBEEF, rd_valid=1.
- With memory filled, pulse clr → busy=1 for 8 cycles.
  - A write of 0x1234 to addr 2 during clear has no effect.
  - Afterwards, addr 2 reads 0x0000.
- Assert reset during clear cycle 4 and release → busy stays high for a full 8 cycles after release; rd_valid=0 throughout.
- With DEPTH=5: write 0xAAAA to addr 6, then read addr 6 → rd_data=0, rd_valid=1. Addresses 0..4 are unchanged.
